// File: rtl/edge_frame_sched.sv
// edge_frame_sched: frame sequencer for the gray/Sobel stages; define EDGE_SCHED_WATCHDOG_EN to build the stall watchdog
module edge_frame_sched #(
  parameter int IMG_HEIGHT = 720,
  parameter int IMG_WIDTH = 540,
  parameter int FRAME_CNT_W = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  localparam int NPIX = IMG_HEIGHT * IMG_WIDTH,
  localparam int PIX_W = $clog2(NPIX + 1)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [FRAME_CNT_W-1:0] num_frames,
  input  logic                   abort,
  input  logic                   pix_wr_en,
  input  logic                   pix_full,
  input  logic                   sobel_done,
  output logic                   stage_rst,
  output logic                   stage_en,
  output logic                   busy,
  output logic                   frame_start,
  output logic                   frame_end,
  output logic                   run_done,
  output logic                   error,
  output logic [FRAME_CNT_W-1:0] frames_done,
  output logic [PIX_W-1:0]       pix_count
);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DONE, ERROR, ABORT} state_t;
  state_t state, state_n;
  logic ph;
  logic [FRAME_CNT_W-1:0] target;
  logic go, acc, ovf, tmo, last, fin;
  logic [PIX_W-1:0] pix_fin;
  assign go = state == IDLE && start && !abort;
  assign acc = state == RUN && pix_wr_en && !pix_full;
  assign ovf = acc && pix_count == PIX_W'(NPIX);
  assign pix_fin = pix_count + PIX_W'(acc);
  assign last = frames_done + 1'b1 == target;
  assign fin = state == RUN && (state_n == CLEAR || state_n == DONE);
`ifdef EDGE_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;
  // count consecutive RUN cycles without an accepted pixel
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) wd <= '0;
    else wd <= (state == RUN && !acc) ? wd + 1'b1 : '0;
  assign tmo = state == RUN && !acc && wd == WD_W'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  // state register, two-cycle phase bit for CLEAR/ABORT, latched frame target
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      ph <= 1'b0;
      target <= '0;
    end else begin
      state <= state_n;
      ph <= state_n == state ? !ph : 1'b0;
      target <= go ? (num_frames == '0 ? FRAME_CNT_W'(1) : num_frames) : target;
    end
  // next state; abort overrides everything outside IDLE
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = go ? CLEAR : IDLE;
      CLEAR:   state_n = ph ? RUN : CLEAR;
      RUN:     state_n = (ovf || tmo) ? ERROR : !sobel_done ? RUN :
                         pix_fin != PIX_W'(NPIX) ? ERROR : last ? DONE : CLEAR;
      ABORT:   state_n = ph ? IDLE : ABORT;
      default: state_n = IDLE;
    endcase
    if (abort && state != IDLE) state_n = ABORT;
  end
  // registered Moore outputs derived from the upcoming state
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      stage_rst <= 1'b1;
      stage_en <= 1'b0;
      busy <= 1'b0;
      frame_start <= 1'b0;
      frame_end <= 1'b0;
      run_done <= 1'b0;
      error <= 1'b0;
      frames_done <= '0;
      pix_count <= '0;
    end else begin
      stage_rst <= state_n != RUN;
      stage_en <= state_n == RUN;
      busy <= state_n == CLEAR || state_n == RUN;
      frame_start <= state == CLEAR && state_n == RUN;
      frame_end <= fin;
      run_done <= state_n == DONE;
      error <= go ? 1'b0 : error | (state_n == ERROR);
      frames_done <= go ? '0 : frames_done + FRAME_CNT_W'(fin);
      pix_count <= state_n == CLEAR ? '0 : ovf ? pix_count : pix_fin;
    end
endmodule
